inst_loop_sequencer: RTL and testbench

- Hardware replacement for the host- or bench-driven instruction loops that feed the systolic array top (init_inst_pulse / idle_flag / flag handshake).
- Holds a table of NUM_DESC loop descriptors. Each descriptor is an opcode plus an A/B address base, a signed stride and an iteration count.
- Walks the table in order and issues one instruction per iteration.
- Adds behaviour the bench loops never had: signed strides with modulo wrap, zero-count skip, an accept timeout, and abort.

---
 rtl/inst_loop_sequencer_pkg.sv | 22 ++
 rtl/inst_loop_sequencer_if.sv | 44 ++++
 rtl/inst_loop_sequencer_addr_gen.sv | 21 ++
 rtl/inst_loop_sequencer.sv | 143 ++++++++++++++
 tb/tb_inst_loop_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_loop_sequencer_pkg.sv
// Shared widths, opcodes and FSM encoding for the loop sequencer and the systolic array top.
// Instruction packing is {opcode, addra, addrb}, opcode in the MSBs.
package inst_loop_sequencer_pkg;

    localparam int OPCODE_BITS_D = 4;
    localparam int ADDR_BITS_D   = 16;

    localparam logic [3:0] AXI_TO_UB_INST    = 4'h1;
    localparam logic [3:0] UB_TO_WEIGHT_INST = 4'h2;
    localparam logic [3:0] MAT_MUL_INST      = 4'h3;
    localparam logic [3:0] ACC_TO_AXI_INST   = 4'h4;

    // Field positions inside the packed instruction word, as a function of address width.
    function automatic int addrb_from(int addr_bits);  return 0;                          endfunction
    function automatic int addra_from(int addr_bits);  return addr_bits;                  endfunction
    function automatic int opcode_from(int addr_bits); return 2 * addr_bits;              endfunction

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT_DONE, S_NEXT, S_FINISH, S_ERR
    } state_t;

endpackage

// File: rtl/inst_loop_sequencer_if.sv
// Host/array-facing bus of the loop sequencer: descriptor config, control and array handshake.
interface inst_loop_sequencer_if #(
    parameter int OPCODE_BITS = 4,
    parameter int ADDR_BITS   = 16,
    parameter int NUM_DESC    = 8,
    parameter int COUNT_BITS  = 12
);
    localparam int IDX_W  = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1;
    localparam int INST_W = OPCODE_BITS + 2 * ADDR_BITS;

    logic                   cfg_wr_en;
    logic [IDX_W-1:0]       cfg_idx;
    logic [OPCODE_BITS-1:0] cfg_opcode;
    logic [ADDR_BITS-1:0]   cfg_a_base;
    logic [ADDR_BITS-1:0]   cfg_b_base;
    logic [ADDR_BITS-1:0]   cfg_a_stride;
    logic [ADDR_BITS-1:0]   cfg_b_stride;
    logic [COUNT_BITS-1:0]  cfg_count;
    logic [IDX_W:0]         num_desc;
    logic                   start;
    logic                   abort;
    logic                   idle_flag;
    logic                   flag;
    logic [INST_W-1:0]      instruction;
    logic                   init_inst_pulse;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [IDX_W-1:0]       cur_desc;
    logic [COUNT_BITS-1:0]  cur_iter;

    modport master (
        output cfg_wr_en, cfg_idx, cfg_opcode, cfg_a_base, cfg_b_base, cfg_a_stride,
               cfg_b_stride, cfg_count, num_desc, start, abort, idle_flag, flag,
        input  instruction, init_inst_pulse, busy, done, error, cur_desc, cur_iter
    );

    modport slave (
        input  cfg_wr_en, cfg_idx, cfg_opcode, cfg_a_base, cfg_b_base, cfg_a_stride,
               cfg_b_stride, cfg_count, num_desc, start, abort, idle_flag, flag,
        output instruction, init_inst_pulse, busy, done, error, cur_desc, cur_iter
    );

endinterface

// File: rtl/inst_loop_sequencer_addr_gen.sv
// Per-channel address accumulator: load the base, then add the signed stride each step.
module inst_addr_gen #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] base,
    input  logic [W-1:0] stride,
    output logic [W-1:0] addr
);

    // A W-bit two's-complement add gives base + i*stride mod 2^W without a multiplier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     addr <= '0;
        else if (load) addr <= base;
        else if (step) addr <= addr + stride;
    end

endmodule

// File: rtl/inst_loop_sequencer.sv
// Walks a descriptor table and issues one array instruction per iteration using the
// init_inst_pulse / idle_flag / flag handshake, with accept timeout and abort.
module inst_loop_sequencer
    import inst_loop_sequencer_pkg::*;
#(
    parameter int OPCODE_BITS    = OPCODE_BITS_D,
    parameter int ADDR_BITS      = ADDR_BITS_D,
    parameter int NUM_DESC       = 8,
    parameter int COUNT_BITS     = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                  clk,
    input logic                  reset,
    inst_loop_sequencer_if.slave bus
);

    localparam int IDX_W = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1;
    localparam int NUM_W = IDX_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [NUM_DESC-1:0][OPCODE_BITS-1:0] tbl_op;
    logic [NUM_DESC-1:0][ADDR_BITS-1:0]   tbl_ab, tbl_bb, tbl_as, tbl_bs;
    logic [NUM_DESC-1:0][COUNT_BITS-1:0]  tbl_cnt;

    state_t                 state;
    logic [NUM_W-1:0]       num_q;
    logic [OPCODE_BITS-1:0] op_q;
    logic [TMO_W-1:0]       tmo;
    logic [ADDR_BITS-1:0]   addr_a, addr_b;
    logic                   run, more_iter, more_desc, gen_load, gen_step;

    assign run = (state == S_LOAD) || (state == S_ISSUE) ||
                 (state == S_WAIT_DONE) || (state == S_NEXT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_op <= '0; tbl_ab <= '0; tbl_bb <= '0;
            tbl_as <= '0; tbl_bs <= '0; tbl_cnt <= '0;
        end else if (bus.cfg_wr_en && !run && (32'(bus.cfg_idx) < NUM_DESC)) begin
            tbl_op[bus.cfg_idx]  <= bus.cfg_opcode;
            tbl_ab[bus.cfg_idx]  <= bus.cfg_a_base;
            tbl_bb[bus.cfg_idx]  <= bus.cfg_b_base;
            tbl_as[bus.cfg_idx]  <= bus.cfg_a_stride;
            tbl_bs[bus.cfg_idx]  <= bus.cfg_b_stride;
            tbl_cnt[bus.cfg_idx] <= bus.cfg_count;
        end
    end

    // Widened by one bit so cur_iter+1 / cur_desc+1 never wrap inside the compare.
    assign more_iter = ({1'b0, bus.cur_iter} + 1'b1) < {1'b0, tbl_cnt[bus.cur_desc]};
    assign more_desc = (NUM_W'(bus.cur_desc) + NUM_W'(1)) < num_q;
    assign gen_load  = (state == S_LOAD) && !bus.abort;
    assign gen_step  = (state == S_NEXT) && more_iter && !bus.abort;

    inst_addr_gen #(.W(ADDR_BITS)) u_gen_a (
        .clk(clk), .reset(reset), .load(gen_load), .step(gen_step),
        .base(tbl_ab[bus.cur_desc]), .stride(tbl_as[bus.cur_desc]), .addr(addr_a)
    );

    inst_addr_gen #(.W(ADDR_BITS)) u_gen_b (
        .clk(clk), .reset(reset), .load(gen_load), .step(gen_step),
        .base(tbl_bb[bus.cur_desc]), .stride(tbl_bs[bus.cur_desc]), .addr(addr_b)
    );

    assign bus.instruction = {op_q, addr_a, addr_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= S_IDLE;
            num_q               <= '0;
            op_q                <= '0;
            tmo                 <= '0;
            bus.init_inst_pulse <= 1'b0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.error           <= 1'b0;
            bus.cur_desc        <= '0;
            bus.cur_iter        <= '0;
        end else begin
            bus.done <= 1'b0;
            if (bus.abort) begin
                state               <= S_IDLE;
                bus.init_inst_pulse <= 1'b0;
                bus.busy            <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (bus.start) begin
                        num_q        <= bus.num_desc;
                        bus.error    <= 1'b0;
                        bus.cur_desc <= '0;
                        bus.cur_iter <= '0;
                        bus.busy     <= 1'b1;
                        state        <= (bus.num_desc == '0) ? S_FINISH : S_LOAD;
                    end
                    S_LOAD: begin
                        op_q <= tbl_op[bus.cur_desc];
                        tmo  <= '0;
                        if (tbl_cnt[bus.cur_desc] == '0) state <= S_NEXT;
                        else begin
                            bus.init_inst_pulse <= 1'b1;
                            state               <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (!bus.idle_flag) begin
                            bus.init_inst_pulse <= 1'b0;
                            state               <= S_WAIT_DONE;
                        end else if (tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                            bus.init_inst_pulse <= 1'b0;
                            bus.error           <= 1'b1;
                            bus.busy            <= 1'b0;
                            state               <= S_ERR;
                        end else tmo <= tmo + 1'b1;
                    end
                    S_WAIT_DONE: if (bus.flag) state <= S_NEXT;
                    S_NEXT: begin
                        if (more_iter) begin
                            bus.cur_iter        <= bus.cur_iter + 1'b1;
                            tmo                 <= '0;
                            bus.init_inst_pulse <= 1'b1;
                            state               <= S_ISSUE;
                        end else if (more_desc) begin
                            bus.cur_desc <= bus.cur_desc + 1'b1;
                            bus.cur_iter <= '0;
                            state        <= S_LOAD;
                        end else state <= S_FINISH;
                    end
                    S_FINISH: begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end
                    S_ERR: begin
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_loop_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed instructions, a negedge monitor
// pops and compares each accepted instruction; a simple array model drives idle_flag/flag.
module tb_inst_loop_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    inst_loop_sequencer_if #(.OPCODE_BITS(4), .ADDR_BITS(12), .NUM_DESC(8), .COUNT_BITS(12)) ifc ();

    inst_loop_sequencer #(
        .OPCODE_BITS(4), .ADDR_BITS(12), .NUM_DESC(8), .COUNT_BITS(12), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(ifc)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    bit array_ok = 1'b1;
    logic [27:0] exp_q[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void exp_push(int op, int a, int b);
        exp_q.push_back({4'(op), 12'(a), 12'(b)});
    endfunction

    // Array model: accept one cycle after the request, report done three cycles later.
    initial begin
        ifc.idle_flag = 1'b1;
        ifc.flag      = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (array_ok && ifc.init_inst_pulse && ifc.idle_flag) begin
                ifc.idle_flag = 1'b0;
                repeat (3) @(posedge clk);
                #1 ifc.flag = 1'b1;
                @(posedge clk); #1;
                ifc.flag      = 1'b0;
                ifc.idle_flag = 1'b1;
            end
        end
    end

    // Monitor: an instruction is accepted in the cycle where the request meets idle_flag low.
    initial forever begin
        @(negedge clk);
        if (ifc.done) done_cnt++;
        if (ifc.init_inst_pulse && !ifc.idle_flag) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got %0h expected none", ifc.instruction);
            end else chk("instruction", 32'(ifc.instruction), 32'(exp_q.pop_front()));
        end
    end

    task automatic wr(int idx, int op, int ab, int as, int bb, int bs, int cnt);
        @(posedge clk); #1;
        ifc.cfg_wr_en    = 1'b1;
        ifc.cfg_idx      = 3'(idx);
        ifc.cfg_opcode   = 4'(op);
        ifc.cfg_a_base   = 12'(ab);
        ifc.cfg_a_stride = 12'(as);
        ifc.cfg_b_base   = 12'(bb);
        ifc.cfg_b_stride = 12'(bs);
        ifc.cfg_count    = 12'(cnt);
        @(posedge clk); #1;
        ifc.cfg_wr_en = 1'b0;
    endtask

    task automatic kick(int nd, bit ab);
        @(posedge clk); #1;
        ifc.num_desc = 4'(nd);
        ifc.start    = 1'b1;
        ifc.abort    = ab;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
    endtask

    task automatic wait_done(string nm, int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (ifc.done) begin
                seen = 1'b1;
                chk({nm, "_busy_at_done"}, 32'(ifc.busy), 0);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got no done expected done within %0d cycles", nm, bound);
        end
    endtask

    task automatic run_check(string nm, int nd, int n_acc);
        int d0 = done_cnt;
        int a0 = acc_cnt;
        kick(nd, 1'b0);
        chk({nm, "_busy"}, 32'(ifc.busy), 1);
        wait_done(nm, 200);
        repeat (2) @(negedge clk);
        chk({nm, "_done_cnt"}, 32'(done_cnt - d0), 1);
        chk({nm, "_acc_cnt"}, 32'(acc_cnt - a0), 32'(n_acc));
        chk({nm, "_q_empty"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int d0, hi, a0;
        bit hit;
        ifc.cfg_wr_en = 0; ifc.cfg_idx = 0; ifc.cfg_opcode = 0;
        ifc.cfg_a_base = 0; ifc.cfg_b_base = 0; ifc.cfg_a_stride = 0; ifc.cfg_b_stride = 0;
        ifc.cfg_count = 0; ifc.num_desc = 0; ifc.start = 0; ifc.abort = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init", 32'(ifc.init_inst_pulse), 0);
        chk("rst_busy", 32'(ifc.busy), 0);
        chk("rst_done", 32'(ifc.done), 0);
        chk("rst_error", 32'(ifc.error), 0);
        chk("rst_instruction", 32'(ifc.instruction), 0);
        chk("rst_cur_desc", 32'(ifc.cur_desc), 0);
        chk("rst_cur_iter", 32'(ifc.cur_iter), 0);
        reset = 1'b0;

        // Basic positive strides
        wr(0, 1, 'h000, 1, 'h000, 16, 4);
        exp_push(1, 'h000, 'h000); exp_push(1, 'h001, 'h010);
        exp_push(1, 'h002, 'h020); exp_push(1, 'h003, 'h030);
        run_check("basic", 1, 4);

        // abort wins over a simultaneous start
        d0 = done_cnt; a0 = acc_cnt;
        kick(1, 1'b1);
        repeat (5) @(negedge clk);
        chk("abort_start_busy", 32'(ifc.busy), 0);
        chk("abort_start_acc", 32'(acc_cnt - a0), 0);

        // Negative stride on B
        wr(0, 3, 'h100, 0, 'hFF0, 'hFF0, 3);
        exp_push(3, 'h100, 'hFF0); exp_push(3, 'h100, 'hFE0); exp_push(3, 'h100, 'hFD0);
        run_check("negstride", 1, 3);

        // Address wrap at 12 bits
        wr(0, 2, 'hFF0, 'h020, 'h005, 0, 2);
        exp_push(2, 'hFF0, 'h005); exp_push(2, 'h010, 'h005);
        run_check("wrap", 1, 2);

        // Three descriptors, middle one skipped
        wr(0, 1, 'h010, 1, 'h020, 2, 2);
        wr(1, 5, 'h0AA, 1, 'h0BB, 1, 0);
        wr(2, 3, 'h300, 7, 'h400, 9, 1);
        exp_push(1, 'h010, 'h020); exp_push(1, 'h011, 'h022); exp_push(3, 'h300, 'h400);
        run_check("skip", 3, 3);
        chk("skip_cur_desc", 32'(ifc.cur_desc), 2);

        // num_desc = 0: done two cycles after start
        d0 = done_cnt;
        kick(0, 1'b0);
        chk("zero_done_early", 32'(ifc.done), 0);
        @(posedge clk); #1;
        chk("zero_done", 32'(ifc.done), 1);
        chk("zero_busy", 32'(ifc.busy), 0);
        @(posedge clk); #1;
        chk("zero_done_width", 32'(ifc.done), 0);

        // Accept timeout
        wr(0, 2, 'h0AA, 0, 'h0BB, 0, 1);
        array_ok = 1'b0;
        d0 = done_cnt;
        hi = 0; hit = 1'b0;
        kick(1, 1'b0);
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (ifc.error) hit = 1'b1;
            else if (ifc.init_inst_pulse) hi++;
        end
        chk("tmo_error", 32'(ifc.error), 1);
        chk("tmo_issue_cycles", 32'(hi), 16);
        chk("tmo_init", 32'(ifc.init_inst_pulse), 0);
        repeat (3) @(negedge clk);
        chk("tmo_busy", 32'(ifc.busy), 0);
        chk("tmo_no_done", 32'(done_cnt - d0), 0);
        chk("tmo_error_sticky", 32'(ifc.error), 1);
        array_ok = 1'b1;
        exp_push(2, 'h0AA, 'h0BB);
        kick(1, 1'b0);
        chk("tmo_error_cleared", 32'(ifc.error), 0);
        wait_done("tmo_rerun", 100);

        // Abort during WAIT_DONE of the second of five iterations
        wr(0, 3, 'h200, 4, 'h007, 0, 5);
        exp_push(3, 'h200, 'h007); exp_push(3, 'h204, 'h007);
        d0 = done_cnt; a0 = acc_cnt; hit = 1'b0;
        kick(1, 1'b0);
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (ifc.cur_iter == 12'd1 && ifc.busy && !ifc.init_inst_pulse && !ifc.idle_flag)
                hit = 1'b1;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL abort_wait: got no WAIT_DONE of iteration 2 expected it within 60 cycles");
        end
        ifc.abort = 1'b1;
        @(posedge clk); #1;
        ifc.abort = 1'b0;
        chk("abort_busy", 32'(ifc.busy), 0);
        chk("abort_init", 32'(ifc.init_inst_pulse), 0);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc.init_inst_pulse) hi++;
        end
        chk("abort_no_issue", 32'(hi), 0);
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        chk("abort_acc_cnt", 32'(acc_cnt - a0), 2);
        chk("abort_q_empty", 32'(exp_q.size()), 0);

        // Asynchronous reset mid-ISSUE
        array_ok = 1'b0;
        hit = 1'b0;
        kick(1, 1'b0);
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (ifc.init_inst_pulse) hit = 1'b1;
        end
        chk("arst_in_issue", 32'(ifc.init_inst_pulse), 1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("arst_init", 32'(ifc.init_inst_pulse), 0);
        chk("arst_busy", 32'(ifc.busy), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        array_ok = 1'b1;
        chk("arst_instruction", 32'(ifc.instruction), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
